btb_update_ctrl: RTL

Sequences all writes into the branch target buffer. Collects target-update requests from several requesters (branch-unit resolve ports), arbitrates them round-robin, buffers them in a small queue with tail coalescing, and emits at most one `ariane_pkg::btb_update_t` per cycle to the BTB. It also owns BTB flush sequencing and debug-mode update suppression. It sits in the frontend between the execute-stage resolve outputs and the BTB update port.

---
 rtl/ariane_pkg.sv | 21 ++
 rtl/rr_arb_btb.sv | 53 +++++
 rtl/btb_update_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg (subset)
// Shared frontend types used by the BTB update path:
//   btb_update_t     - one BTB write: valid qualifier, branch pc, target address
//   btb_ctrl_state_e - sequencing state of btb_update_ctrl
package ariane_pkg;

   localparam int unsigned VLEN = 64;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic [VLEN-1:0] target_address;
   } btb_update_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DEBUG = 2'd2
   } btb_ctrl_state_e;

endpackage

// File: rtl/rr_arb_btb.sv
// rr_arb_btb
// Round-robin grant over NR_REQ requesters with its own pointer register.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req         - per-requester valid
//   accept      - the current grant was taken this cycle (pointer advances)
//   gnt         - one-hot grant (zero when nothing is requesting)
//   gnt_valid   - some requester is granted
//   gnt_idx     - index of the granted requester
module rr_arb_btb #(
   parameter  int unsigned NR_REQ = 2,
   localparam int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NR_REQ-1:0] req,
   input  logic              accept,
   output logic [NR_REQ-1:0] gnt,
   output logic              gnt_valid,
   output logic [IDX_W-1:0]  gnt_idx
);

   logic [IDX_W-1:0] ptr_q;
   int unsigned      idx;

   // Scan from the pointer upward, wrapping once; first valid requester wins.
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NR_REQ; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NR_REQ) idx = idx - NR_REQ;
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx[IDX_W-1:0];
         end
      end
      if (gnt_valid) gnt[gnt_idx] = 1'b1;
   end

   // Pointer moves past the winner only when the grant is actually taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept && gnt_valid) begin
         if (gnt_idx == IDX_W'(NR_REQ - 1)) ptr_q <= '0;
         else                              ptr_q <= gnt_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
// Sequences all BTB writes: round-robin arbitration of resolve-port updates,
// a small circular queue with tail coalescing, flush sequencing and
// debug-mode suppression. At most one update per cycle leaves on btb_update_o.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - invalidate the whole BTB (highest priority)
//   debug_mode_i   - core in debug mode; updates are dropped, queue frozen
//   req_valid_i    - per-requester update valid
//   req_update_i   - per-requester pc/target (.valid field ignored)
//   req_ready_o    - one-hot (or zero) acceptance, combinational
//   btb_update_o   - head of queue to the BTB, .valid qualifies
//   btb_flush_o    - one-cycle BTB flush strobe
//   busy_o         - queue non-empty or flush in progress
module btb_update_ctrl
   import ariane_pkg::*;
#(
   parameter int unsigned NR_REQ = 2,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     debug_mode_i,
   input  logic [NR_REQ-1:0]        req_valid_i,
   input  btb_update_t [NR_REQ-1:0] req_update_i,
   output logic [NR_REQ-1:0]        req_ready_o,
   output btb_update_t              btb_update_o,
   output logic                     btb_flush_o,
   output logic                     busy_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

   btb_ctrl_state_e  state_q;
   logic             flush_q;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] tail_last;

   // Entry storage carries no reset: nothing reads it unless count_q says
   // the entry is live, so it maps onto plain RAM-style registers.
   logic [VLEN-1:0]  pc_mem     [DEPTH];
   logic [VLEN-1:0]  target_mem [DEPTH];

   logic [NR_REQ-1:0] gnt;
   logic              gnt_valid;
   logic [IDX_W-1:0]  gnt_idx;
   btb_update_t       sel_update;

   logic full;
   logic pop;
   logic coalesce;
   logic accept;
   logic push;
   logic coal_wr;

   rr_arb_btb #(
      .NR_REQ (NR_REQ)
   ) i_arb (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .req       (req_valid_i),
      .accept    (accept),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign sel_update = req_update_i[gnt_idx];
   assign tail_last  = tail_q - PTR_W'(1);
   assign full       = (count_q == CNT_W'(DEPTH));

   // Drain only in RUN, and stop the same cycle flush or debug is raised.
   assign pop = (state_q == RUN) && (count_q != '0) && !flush_i && !debug_mode_i;

   // The tail entry is only being popped when it is also the head (count 1).
   assign coalesce = (count_q != '0) && (sel_update.pc == pc_mem[tail_last])
                     && !(pop && (count_q == CNT_W'(1)));

   always_comb begin
      accept = 1'b0;
      case (state_q)
         RUN:     accept = gnt_valid && !flush_i && (coalesce || !full);
         DEBUG:   accept = gnt_valid && !flush_i;   // taken and discarded
         default: accept = 1'b0;
      endcase
   end

   assign push    = accept && (state_q == RUN) && !coalesce;
   assign coal_wr = accept && (state_q == RUN) && coalesce;

   // Gating with rst_ni keeps ready low while reset is held, even though
   // the arbiter sees an empty queue in RUN.
   assign req_ready_o = (rst_ni && accept) ? gnt : '0;

   always_comb begin
      btb_update_o = '0;
      if (pop) begin
         btb_update_o.valid          = 1'b1;
         btb_update_o.pc             = pc_mem[head_q];
         btb_update_o.target_address = target_mem[head_q];
      end
   end

   assign btb_flush_o = flush_q;
   assign busy_o      = (count_q != '0) || flush_q;

   // Control FSM; flush_q is the registered decode of the FLUSH state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         flush_q <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  flush_q <= 1'b1;
               end else if (debug_mode_i) begin
                  state_q <= DEBUG;
               end
            end
            FLUSH: begin
               state_q <= debug_mode_i ? DEBUG : RUN;
            end
            DEBUG: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  flush_q <= 1'b1;
               end else if (!debug_mode_i) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (state_q == FLUSH) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry writes: push fills the tail slot, coalesce rewrites the last target.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[tail_q]     <= sel_update.pc;
         target_mem[tail_q] <= sel_update.target_address;
      end else if (coal_wr) begin
         target_mem[tail_last] <= sel_update.target_address;
      end
   end

endmodule
